// File: rtl/keyboard_event_ctrl.sv
// Keyboard event controller: scan-code flags -> per-channel level/edge/repeat pulses -> event FIFO.
// Auto-repeat FSMs and counters are built only when KEY_AUTOREPEAT_EN is defined.

// Generic single-clock FIFO, power-of-two depth.
// Latency: rd_vld rises one cycle after the first write into an empty queue.
// Backpressure: wr_rdy low when full, except a same-cycle pop frees the slot.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  output logic         wr_rdy,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  assign rd_vld = (count != '0);
  assign pop    = rd_vld && rd_rdy;
  assign wr_rdy = (count != (AW+1)'(DEPTH)) || pop;
  assign push   = wr_vld && wr_rdy;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end
endmodule

// Maps NUM_KEYS scan codes to channels; emits press/release/repeat pulses and queued events.
// Latency: level/pulses 1 cycle after key_down; event written 2 cycles after its pulse.
// Backpressure: evt_ready low parks events in per-channel/type pending flags; a re-pulse sets evt_overflow.
module keyboard_event_ctrl #(
  parameter int                    NUM_KEYS     = 12,
  parameter logic [9*NUM_KEYS-1:0] KEY_CODES    = {9'h042, 9'h03B, 9'h04B, 9'h043,
                                                   9'h02B, 9'h023, 9'h01B, 9'h01C,
                                                   9'h02C, 9'h02D, 9'h01D, 9'h05A},
  parameter int                    REPEAT_DELAY = 50_000_000,
  parameter int                    REPEAT_RATE  = 10_000_000,
  parameter int                    FIFO_DEPTH   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [511:0]        key_down,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [3:0]          evt_key,
  output logic [1:0]          evt_type,
  output logic                evt_overflow,
  input  logic                overflow_clr
);
  localparam int NP    = 3 * NUM_KEYS;
  localparam int SEL_W = (NP > 1) ? $clog2(NP) : 1;

  logic [NUM_KEYS-1:0] key_nxt;
  logic [NUM_KEYS-1:0] rpt_vec;
  logic                unused_key_down;

  assign unused_key_down = ^key_down;

  always_comb begin
    key_nxt = '0;
    for (int i = 0; i < NUM_KEYS; i++) key_nxt[i] = key_down[KEY_CODES[9*i +: 9]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      key_repeat  <= '0;
    end else begin
      key_level   <= key_nxt;
      key_press   <= key_nxt & ~key_level;
      key_release <= ~key_nxt & key_level;
      key_repeat  <= rpt_vec;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rpt_state_t;

  // The FSM advances on the same edge key_level does, so cnt is the held-cycle count.
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_rpt
    rpt_state_t       state;
    rpt_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             rpt_nxt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rpt_nxt   = 1'b0;
      if (!key_nxt[g]) begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state_nxt = ST_DELAY;
            cnt_nxt   = CNT_W'(1);
          end
          ST_DELAY: begin
            if (cnt >= DLY_LAST) begin
              state_nxt = ST_REPEAT;
              cnt_nxt   = '0;
              rpt_nxt   = 1'b1;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (cnt >= RATE_LAST) begin
              cnt_nxt = '0;
              rpt_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
          default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end
        endcase
      end
    end

    assign rpt_vec[g] = rpt_nxt;
  end
`else
  assign rpt_vec = '0;
`endif

  // Pending bit 3*ch+type: type 0 press, 1 release, 2 repeat.
  logic [NP-1:0]    pend;
  logic [NP-1:0]    pulse_vec;
  logic [NP-1:0]    clr_vec;
  logic [SEL_W-1:0] sel;
  logic [3:0]       arb_key;
  logic [1:0]       arb_typ;
  logic             arb_vld;
  logic             arb_rdy;
  logic             ovf_set;
  logic [5:0]       fifo_dat;

  always_comb begin
    pulse_vec = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      pulse_vec[3*i]   = key_press[i];
      pulse_vec[3*i+1] = key_release[i];
      pulse_vec[3*i+2] = key_repeat[i];
    end
  end

  // Scan from the top so the lowest channel/type wins.
  always_comb begin
    sel     = '0;
    arb_key = '0;
    arb_typ = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      for (int t = 2; t >= 0; t--) begin
        if (pend[3*i+t]) begin
          sel     = SEL_W'(3*i + t);
          arb_key = 4'(i);
          arb_typ = 2'(t);
        end
      end
    end
  end

  assign arb_vld = |pend;

  always_comb begin
    clr_vec = '0;
    if (arb_vld && arb_rdy) clr_vec[sel] = 1'b1;
  end

  assign ovf_set = |(pulse_vec & pend & ~clr_vec);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend         <= '0;
      evt_overflow <= 1'b0;
    end else begin
      pend <= (pend & ~clr_vec) | pulse_vec;
      if (overflow_clr)  evt_overflow <= 1'b0;
      else if (ovf_set)  evt_overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .W     (6),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (arb_vld),
    .wr_rdy (arb_rdy),
    .wr_dat ({arb_key, arb_typ}),
    .rd_vld (evt_valid),
    .rd_rdy (evt_ready),
    .rd_dat (fifo_dat)
  );

  assign evt_key  = evt_valid ? fifo_dat[5:2] : 4'd0;
  assign evt_type = evt_valid ? fifo_dat[1:0] : 2'd0;
endmodule

// File: tb/tb_keyboard_event_ctrl.sv
// Directed bench for keyboard_event_ctrl (short repeat timing, 2-deep event queue).
module tb_keyboard_event_ctrl;
  localparam int NK = 12;
  localparam logic [8:0] C_ENTER = 9'h05A;
  localparam logic [8:0] C_W     = 9'h01D;
  localparam logic [8:0] C_R     = 9'h02D;
  localparam logic [8:0] C_T     = 9'h02C;
  localparam logic [8:0] C_A     = 9'h01C;
  localparam logic [8:0] C_S     = 9'h01B;

  logic          clk = 1'b0;
  logic          rst;
  logic [511:0]  key_down;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_repeat;
  logic          evt_valid;
  logic          evt_ready;
  logic [3:0]    evt_key;
  logic [1:0]    evt_type;
  logic          evt_overflow;
  logic          overflow_clr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  keyboard_event_ctrl #(
    .NUM_KEYS     (NK),
    .REPEAT_DELAY (10),
    .REPEAT_RATE  (4),
    .FIFO_DEPTH   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_down     (key_down),
    .key_level    (key_level),
    .key_press    (key_press),
    .key_release  (key_release),
    .key_repeat   (key_repeat),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_key      (evt_key),
    .evt_type     (evt_type),
    .evt_overflow (evt_overflow),
    .overflow_clr (overflow_clr)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle();
    key_down     = '0;
    evt_ready    = 1'b1;
    overflow_clr = 1'b0;
    tick(12);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    evt_ready    = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    logic [55:0] all_out;
    rst = 1'b0; key_down = '0; evt_ready = 1'b0; overflow_clr = 1'b0;
    tick(2);
    all_out = {key_level, key_press, key_release, key_repeat, evt_valid, evt_key, evt_type, evt_overflow};
    checks++;
    if (all_out !== 56'd0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
    rst = 1'b1;
    tick(2);
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++; $display("FAIL reset_fifo_empty got=%b exp=0", evt_valid);
    end
  endtask

  task automatic test_press_release();
    logic [6:0] ev;
    key_down[C_W] = 1'b1;
    tick(1);
    checks++;
    if (key_press !== 12'h002) begin
      failures++; $display("FAIL w_press got=%h exp=002", key_press);
    end
    checks++;
    if (key_level !== 12'h002) begin
      failures++; $display("FAIL w_level got=%h exp=002", key_level);
    end
    tick(1);
    checks++;
    if ({key_press, evt_valid} !== 13'd0) begin
      failures++; $display("FAIL w_press_once_no_valid got=%h exp=0", {key_press, evt_valid});
    end
    tick(1);
    key_down[C_W] = 1'b0;
    ev = {evt_valid, evt_key, evt_type};
    checks++;
    if (ev !== 7'b1_0001_00) begin
      failures++; $display("FAIL w_first_evt got=%b exp=1000100", ev);
    end
    tick(1);
    checks++;
    if (key_release !== 12'h002) begin
      failures++; $display("FAIL w_release got=%h exp=002", key_release);
    end
    tick(2);
    ev = {evt_valid, evt_key, evt_type};
    checks++;
    if (ev !== 7'b1_0001_00) begin
      failures++; $display("FAIL w_evt_hold got=%b exp=1000100", ev);
    end
    evt_ready = 1'b1;
    tick(1);
    ev = {evt_valid, evt_key, evt_type};
    checks++;
    if (ev !== 7'b1_0001_01) begin
      failures++; $display("FAIL w_second_evt got=%b exp=1000101", ev);
    end
    tick(1);
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++; $display("FAIL w_drained got=%b exp=0", evt_valid);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_autorepeat();
    logic [NK-1:0] exp_rep;
    int n_rep = 0;
    int exp_n = 0;
`ifdef KEY_AUTOREPEAT_EN
    exp_n = 6;
`endif
    evt_ready = 1'b1;
    key_down[C_A] = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      tick(1);
      exp_rep = '0;
`ifdef KEY_AUTOREPEAT_EN
      if (k >= 10 && k <= 30 && ((k - 10) % 4) == 0) exp_rep[4] = 1'b1;
`endif
      if (key_repeat[4] === 1'b1) n_rep++;
      checks++;
      if (key_repeat !== exp_rep) begin
        failures++; $display("FAIL repeat_cycle_%0d got=%h exp=%h", k, key_repeat, exp_rep);
      end
      if (k == 30) key_down[C_A] = 1'b0;
    end
    checks++;
    if (key_release !== 12'h010) begin
      failures++; $display("FAIL repeat_release got=%h exp=010", key_release);
    end
    checks++;
    if (n_rep !== exp_n) begin
      failures++; $display("FAIL repeat_count got=%0d exp=%0d", n_rep, exp_n);
    end
    tick(4);
    checks++;
    if ({evt_overflow, evt_valid} !== 2'b00) begin
      failures++; $display("FAIL repeat_no_ovf got=%b exp=00", {evt_overflow, evt_valid});
    end
  endtask

  task automatic test_same_cycle();
    logic [6:0] ev;
    evt_ready = 1'b1;
    key_down[C_ENTER] = 1'b1;
    key_down[C_S]     = 1'b1;
    tick(3);
    ev = {evt_valid, evt_key, evt_type};
    checks++;
    if (ev !== 7'b1_0000_00) begin
      failures++; $display("FAIL same_cycle_ch0 got=%b exp=1000000", ev);
    end
    tick(1);
    ev = {evt_valid, evt_key, evt_type};
    checks++;
    if (ev !== 7'b1_0101_00) begin
      failures++; $display("FAIL same_cycle_ch5 got=%b exp=1010100", ev);
    end
    tick(1);
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++; $display("FAIL same_cycle_empty got=%b exp=0", evt_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ev;
    logic [6:0] exp_ev [4];
    exp_ev[0] = 7'b1_0000_00;
    exp_ev[1] = 7'b1_0001_00;
    exp_ev[2] = 7'b1_0010_00;
    exp_ev[3] = 7'b1_0011_00;
    evt_ready = 1'b0;
    key_down[C_ENTER] = 1'b1;
    key_down[C_W]     = 1'b1;
    key_down[C_R]     = 1'b1;
    key_down[C_T]     = 1'b1;
    tick(5);
    ev = {evt_valid, evt_key, evt_type};
    checks++;
    if (ev !== exp_ev[0]) begin
      failures++; $display("FAIL full_head got=%b exp=%b", ev, exp_ev[0]);
    end
    tick(1);
    ev = {evt_valid, evt_key, evt_type};
    checks++;
    if (ev !== exp_ev[0]) begin
      failures++; $display("FAIL full_head_hold got=%b exp=%b", ev, exp_ev[0]);
    end
    evt_ready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      tick(1);
      ev = {evt_valid, evt_key, evt_type};
      checks++;
      if (ev !== exp_ev[j]) begin
        failures++; $display("FAIL drain_%0d got=%b exp=%b", j, ev, exp_ev[j]);
      end
    end
    tick(1);
    checks++;
    if ({evt_valid, evt_overflow} !== 2'b00) begin
      failures++; $display("FAIL drain_end got=%b exp=00", {evt_valid, evt_overflow});
    end
  endtask

  task automatic test_overflow();
    evt_ready = 1'b0;
    key_down[C_ENTER] = 1'b1;
    key_down[C_W]     = 1'b1;
    key_down[C_T]     = 1'b1;
    tick(5);
    key_down[C_T] = 1'b0;
    checks++;
    if (evt_overflow !== 1'b0) begin
      failures++; $display("FAIL ovf_pre got=%b exp=0", evt_overflow);
    end
    tick(2);
    key_down[C_T] = 1'b1;
    tick(1);
    checks++;
    if ({key_press[3], evt_overflow} !== 2'b10) begin
      failures++; $display("FAIL ovf_repress got=%b exp=10", {key_press[3], evt_overflow});
    end
    tick(1);
    checks++;
    if (evt_overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_set got=%b exp=1", evt_overflow);
    end
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    checks++;
    if (evt_overflow !== 1'b0) begin
      failures++; $display("FAIL ovf_clear got=%b exp=0", evt_overflow);
    end
    tick(1);
    key_down[C_T] = 1'b0;
    overflow_clr  = 1'b1;
    tick(2);
    checks++;
    if (evt_overflow !== 1'b0) begin
      failures++; $display("FAIL ovf_clr_prio_rel got=%b exp=0", evt_overflow);
    end
    key_down[C_T] = 1'b1;
    tick(2);
    checks++;
    if (evt_overflow !== 1'b0) begin
      failures++; $display("FAIL ovf_clr_prio_press got=%b exp=0", evt_overflow);
    end
    overflow_clr = 1'b0;
    tick(1);
    checks++;
    if (evt_overflow !== 1'b0) begin
      failures++; $display("FAIL ovf_stays_clear got=%b exp=0", evt_overflow);
    end
  endtask

  task automatic test_reset_mid_repeat();
    logic [55:0] all_out;
    logic [6:0]  ev;
    evt_ready = 1'b1;
    key_down[C_A] = 1'b1;
    tick(12);
    checks++;
    if (key_level[4] !== 1'b1) begin
      failures++; $display("FAIL pre_reset_level got=%b exp=1", key_level[4]);
    end
    rst = 1'b0;
    #1;
    all_out = {key_level, key_press, key_release, key_repeat, evt_valid, evt_key, evt_type, evt_overflow};
    checks++;
    if (all_out !== 56'd0) begin
      failures++; $display("FAIL reset_async got=%h exp=0", all_out);
    end
    tick(1);
    rst = 1'b1;
    tick(1);
    checks++;
    if ({key_press, key_release} !== {12'h010, 12'h000}) begin
      failures++; $display("FAIL press_after_reset got=%h exp=010000", {key_press, key_release});
    end
    tick(2);
    ev = {evt_valid, evt_key, evt_type};
    checks++;
    if (ev !== 7'b1_0100_00) begin
      failures++; $display("FAIL evt_after_reset got=%b exp=1010000", ev);
    end
    tick(1);
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++; $display("FAIL no_release_evt got=%b exp=0", evt_valid);
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    settle();
    test_autorepeat();
    settle();
    test_same_cycle();
    settle();
    test_back_to_back();
    settle();
    test_overflow();
    settle();
    test_reset_mid_repeat();
    settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
